// File: rtl/pulse_cmd_sender.sv
// pulse_cmd_sender
//   Host-side initiator for the 5-byte pulse-parameter UART command.
//   A command {ctrl, data} is accepted on a valid/ready port, sent as
//   data[7:0], data[15:8], data[23:16], data[31:24], ctrl through a UART byte
//   interface, and then the block waits for the 1-byte checksum echo
//   (8-bit wrapping sum of the four data bytes) and reports pass/fail.
//
//   Optional feature macro: PULSE_CMD_RETRY_EN
//     defined   - a failed attempt (mismatch, timeout, framing error) resends the
//                 whole frame up to MAX_RETRIES extra times before reporting.
//     undefined - single attempt; any failure is reported immediately.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   cmd_valid/ready    command handshake; ready only while idle
//   cmd_ctrl/cmd_data  control byte and 32-bit parameter, sampled on accept
//   transmit, tx_byte  one-cycle byte request to the UART transmitter
//   is_transmitting    UART transmitter busy
//   received, rx_byte  UART byte-received strobe and byte
//   recv_error         UART framing error strobe
//   busy               frame in progress (inverse of cmd_ready)
//   done, ok           one-cycle completion pulse and its pass/fail result
//   echo_byte          last byte seen while waiting for the echo
module pulse_cmd_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_ctrl,
  input  logic [31:0] cmd_data,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [7:0]  echo_byte
);

  typedef enum logic [2:0] {
    IDLE, LOAD, GUARD, WAIT_TX, WAIT_ECHO, DONE
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [39:0] frame;
  logic [2:0]  idx;
  logic [7:0]  expected;
  logic [31:0] timer;
  logic [7:0]  cur_byte;
  logic        accept, last_byte, attempt_end, attempt_pass, retry;

  // Frame is kept intact and indexed so a retry can restart from byte 0.
  always_comb begin
    cur_byte = frame[39:32];
    case (idx)
      3'd0:    cur_byte = frame[7:0];
      3'd1:    cur_byte = frame[15:8];
      3'd2:    cur_byte = frame[23:16];
      3'd3:    cur_byte = frame[31:24];
      default: cur_byte = frame[39:32];
    endcase
  end

  assign accept       = cmd_valid && (state == IDLE);
  assign last_byte    = (idx == 3'd4);
  // A framing error wins over a same-cycle byte strobe.
  assign attempt_pass = (state == WAIT_ECHO) && received && !recv_error &&
                        (rx_byte == expected);
  assign attempt_end  = (state == WAIT_ECHO) &&
                        (received || recv_error || (timer == TIMER_LAST));

`ifdef PULSE_CMD_RETRY_EN
  logic [31:0] attempts;

  assign retry = attempt_end && !attempt_pass && (attempts < MAX_RETRIES);

  always_ff @(posedge clk) begin
    if (rst)         attempts <= '0;
    else if (accept) attempts <= '0;
    else if (retry)  attempts <= attempts + 32'd1;
  end
`else
  logic unused_cfg;

  assign retry      = 1'b0;
  assign unused_cfg = ^MAX_RETRIES;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = LOAD;
      LOAD:      if (!is_transmitting) state_nxt = GUARD;
      GUARD:     state_nxt = WAIT_TX;
      WAIT_TX:   if (!is_transmitting) state_nxt = last_byte ? WAIT_ECHO : LOAD;
      WAIT_ECHO: begin
        if (retry)            state_nxt = LOAD;
        else if (attempt_end) state_nxt = DONE;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Datapath: frame, byte index, checksum, echo result, timer, UART request
  always_ff @(posedge clk) begin
    if (rst) begin
      frame     <= '0;
      idx       <= '0;
      expected  <= '0;
      timer     <= '0;
      transmit  <= 1'b0;
      tx_byte   <= '0;
      ok        <= 1'b0;
      echo_byte <= '0;
    end else begin
      transmit <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          frame     <= {cmd_ctrl, cmd_data};
          idx       <= '0;
          expected  <= cmd_data[7:0] + cmd_data[15:8] +
                       cmd_data[23:16] + cmd_data[31:24];
          echo_byte <= '0;
        end
        LOAD: if (!is_transmitting) begin
          transmit <= 1'b1;
          tx_byte  <= cur_byte;
        end
        WAIT_TX: if (!is_transmitting) begin
          if (last_byte) timer <= '0;
          else           idx   <= idx + 3'd1;
        end
        WAIT_ECHO: begin
          if (timer != '1) timer <= timer + 32'd1;
          if (recv_error) begin
            ok <= 1'b0;
          end else if (received) begin
            echo_byte <= rx_byte;
            ok        <= (rx_byte == expected);
          end else if (timer == TIMER_LAST) begin
            ok <= 1'b0;
          end
          if (retry) idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_cmd_sender.sv
// Bench for pulse_cmd_sender: a small UART model holds is_transmitting for 4
// cycles after each request; expected wire bytes and completion results are
// queued when a command is driven and checked as the DUT produces them.
module tb_pulse_cmd_sender;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_ctrl = '0;
  logic [31:0] cmd_data = '0;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        recv_error = 1'b0;
  logic        busy, done, ok;
  logic [7:0]  echo_byte;

  always #5 clk = ~clk;

  pulse_cmd_sender #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data), .transmit(transmit),
    .tx_byte(tx_byte), .is_transmitting(is_transmitting), .received(received),
    .rx_byte(rx_byte), .recv_error(recv_error), .busy(busy), .done(done),
    .ok(ok), .echo_byte(echo_byte)
  );

  typedef struct { logic ok; logic [7:0] echo; } res_t;

  logic [7:0] tx_q[$];
  res_t       res_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, tx_cnt = 0, done_cnt = 0, last_tx_cyc = 0;
  int ubusy = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model
  always @(posedge clk) begin
    if (transmit)       ubusy <= 4;
    else if (ubusy > 0) ubusy <= ubusy - 1;
  end
  assign is_transmitting = (ubusy != 0);

  // Output monitor / scoreboard
  always @(negedge clk) begin : mon
    res_t r;
    if (transmit) begin
      tx_cnt      <= tx_cnt + 1;
      last_tx_cyc <= cyc;
      if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
      else                  chk("tx_byte", tx_byte, tx_q.pop_front());
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (res_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        r = res_q.pop_front();
        chk("ok", ok, r.ok);
        chk("echo_byte", echo_byte, r.echo);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_tx(input int target, input string tag);
    int n = 0;
    while (tx_cnt < target && n < 300) begin tick(); n++; end
    if (tx_cnt < target) chk(tag, tx_cnt, target);
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [31:0] d);
    for (int i = 0; i < 4; i++) tx_q.push_back(d[8*i +: 8]);
    tx_q.push_back(c);
  endtask

  // mode: 0 = echo ev, 1 = no echo (timeout), 2 = framing error
  task automatic run_cmd(input logic [7:0] c, input logic [31:0] d, input int mode,
                         input logic [7:0] ev, input bit hold, input bit stray);
    logic [7:0] sum;
    bit   pass;
    int   att, n, base_done, tgt;
    res_t r;
    sum  = d[7:0] + d[15:8] + d[23:16] + d[31:24];
    pass = (mode == 0) && (ev == sum);
    att  = 1;
`ifdef PULSE_CMD_RETRY_EN
    if (!pass) att = 3;
`endif
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("ready_before", cmd_ready, 1);
    base_done = done_cnt;
    cmd_ctrl = c; cmd_data = d; cmd_valid = 1'b1;
    r.ok = pass; r.echo = (mode == 0) ? ev : 8'h00;
    res_q.push_back(r);
    tick();
    if (!hold) begin
      cmd_valid = 1'b0; cmd_ctrl = 8'($urandom); cmd_data = $urandom;
    end
    chk("busy_after_accept", busy, 1);
    for (int a = 0; a < att; a++) begin
      tgt = tx_cnt + 5;
      push_frame(c, d);
      if (stray) begin
        wait_tx(tgt - 3, "stray_wait");
        rx_byte = sum; received = 1'b1;
        tick();
        received = 1'b0;
      end
      wait_tx(tgt, "tx_count");
      n = 0;
      while (is_transmitting && n < 50) begin tick(); n++; end
      tick(); tick();
      chk("no_early_done", done_cnt, base_done);
      if (hold) chk("ready_low_held", cmd_ready, 0);
      if (mode == 0) begin
        rx_byte = ev; received = 1'b1;
        tick();
        received = 1'b0; rx_byte = 8'($urandom);
        chk("echo_done_lat", done, a == att - 1);
      end else if (mode == 2) begin
        rx_byte = sum; received = 1'b1; recv_error = 1'b1;
        tick();
        received = 1'b0; recv_error = 1'b0;
        chk("err_done_lat", done, a == att - 1);
      end else if (a == att - 1) begin
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        // WAIT_ECHO entry is 6 cycles after the last transmit with this UART model
        chk("timeout_lat", cyc - last_tx_cyc, TO + 6);
      end
    end
    if (hold) cmd_valid = 1'b0;
    tick();
    chk("ready_after_done", cmd_ready, 1);
    chk("done_one_cycle", done, 0);
    tick();
    chk("single_done", done_cnt - base_done, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic reset_mid();
    int tgt, n;
    tgt = tx_cnt + 2;
    cmd_ctrl = 8'h03; cmd_data = 32'hA1B2C3D4; cmd_valid = 1'b1;
    push_frame(8'h03, 32'hA1B2C3D4);
    tick();
    cmd_valid = 1'b0;
    wait_tx(tgt, "rst_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_transmit", transmit, 0);
    tx_q.delete();
    n = tx_cnt;
    repeat (20) tick();
    chk("rst_no_tx", tx_cnt, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy0", busy, 0);
    chk("rst_transmit0", transmit, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", ok, 0);
    chk("rst_echo", echo_byte, 0);
    rst = 1'b0;
    tick();
    run_cmd(8'h00, 32'h000000C8, 0, 8'hC8, 1'b0, 1'b0);
    run_cmd(8'h01, 32'hFFFFFFFF, 0, 8'hFC, 1'b0, 1'b0);
    run_cmd(8'h00, 32'h00010002, 0, 8'h04, 1'b0, 1'b0);
    run_cmd(8'h02, 32'h12345678, 1, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h03, 32'h0000FF01, 2, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h04, 32'h01020304, 0, 8'h0A, 1'b1, 1'b1);
    reset_mid();
    run_cmd(8'h05, 32'h00000064, 0, 8'h64, 1'b0, 1'b0);
    repeat (5) tick();
    chk("queues_drained", tx_q.size() + res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
